// File: rtl/mem_access_unit_pkg.sv
// Shared load/store mode encodings, FSM states and alignment helper for mem_access_unit.
package mem_access_unit_pkg;

    localparam int L_S_MODE_W = 3;

    typedef enum logic [L_S_MODE_W-1:0] {
        L_S_WORD   = 3'd0,
        L_S_HALF   = 3'd1,
        L_S_HALF_U = 3'd2,
        L_S_BYTE   = 3'd3,
        L_S_BYTE_U = 3'd4
    } l_s_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } mau_state_e;

    // Unrecognised encodings fall into the WORD rule.
    function automatic logic is_misaligned(input logic [L_S_MODE_W-1:0] mode,
                                           input logic [1:0]            off);
        case (mode)
            L_S_BYTE, L_S_BYTE_U: return 1'b0;
            L_S_HALF, L_S_HALF_U: return off[0];
            default:              return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/ls_lane_fmt.sv
// Combinational lane formatter: byte enables, store replication and load extraction.
module ls_lane_fmt
    import mem_access_unit_pkg::*;
(
    input  logic [L_S_MODE_W-1:0] l_s_mode,
    input  logic [1:0]            byte_off,
    input  logic [31:0]           wdata,
    input  logic [31:0]           bus_rdata,
    output logic [3:0]            be,
    output logic [31:0]           wdata_rep,
    output logic [31:0]           rdata_fmt
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = bus_rdata[7:0];
        case (byte_off)
            2'd1:    byte_lane = bus_rdata[15:8];
            2'd2:    byte_lane = bus_rdata[23:16];
            2'd3:    byte_lane = bus_rdata[31:24];
            default: byte_lane = bus_rdata[7:0];
        endcase
        half_lane = byte_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    end

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_fmt = bus_rdata;
        case (l_s_mode)
            L_S_BYTE: begin
                be        = 4'b0001 << byte_off;
                wdata_rep = {4{wdata[7:0]}};
                rdata_fmt = {{24{byte_lane[7]}}, byte_lane};
            end
            L_S_BYTE_U: begin
                be        = 4'b0001 << byte_off;
                wdata_rep = {4{wdata[7:0]}};
                rdata_fmt = {24'd0, byte_lane};
            end
            L_S_HALF: begin
                be        = byte_off[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_fmt = {{16{half_lane[15]}}, half_lane};
            end
            L_S_HALF_U: begin
                be        = byte_off[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_fmt = {16'd0, half_lane};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_fmt = bus_rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: accepts one pipeline memory request, runs a single bus transfer
// with timeout, and returns a one-cycle formatted response.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  mem_read_en,
    input  logic                  mem_write_en,
    input  logic [L_S_MODE_W-1:0] l_s_mode,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic                  resp_valid,
    output logic [31:0]           rdata,
    output logic                  resp_err,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [31:0]           bus_addr,
    output logic [3:0]            bus_be,
    output logic [31:0]           bus_wdata,
    input  logic                  bus_ack,
    input  logic [31:0]           bus_rdata
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    mau_state_e state, state_nxt;

    logic [L_S_MODE_W-1:0] mode_q;
    logic [1:0]            off_q;
    logic [7:0]            cnt;

    logic                  accept;
    logic                  illegal;
    logic                  misal;
    logic                  timed_out;
    logic [L_S_MODE_W-1:0] fmt_mode;
    logic [1:0]            fmt_off;
    logic [3:0]            fmt_be;
    logic [31:0]           fmt_wdata;
    logic [31:0]           fmt_rdata;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_ready && req_valid && (mem_read_en ^ mem_write_en);
    assign illegal   = req_ready && req_valid && mem_read_en && mem_write_en;
    assign misal     = is_misaligned(l_s_mode, addr[1:0]);
    assign timed_out = (cnt == CNT_LAST);

    // One formatter serves both phases: live request fields while idle
    // (enables/replication), latched fields afterwards (load extraction).
    assign fmt_mode = req_ready ? l_s_mode  : mode_q;
    assign fmt_off  = req_ready ? addr[1:0] : off_q;

    ls_lane_fmt u_fmt (
        .l_s_mode  (fmt_mode),
        .byte_off  (fmt_off),
        .wdata     (wdata),
        .bus_rdata (bus_rdata),
        .be        (fmt_be),
        .wdata_rep (fmt_wdata),
        .rdata_fmt (fmt_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (illegal || (accept && misal)) state_nxt = ST_RESP;
                else if (accept)                  state_nxt = ST_BUS;
            end
            ST_BUS: begin
                if (bus_ack || timed_out) state_nxt = ST_RESP;
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_be     <= '0;
            bus_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            rdata      <= '0;
            cnt        <= '0;
            mode_q     <= '0;
            off_q      <= '0;
        end else begin
            bus_req    <= (state_nxt == ST_BUS);
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (illegal || (accept && misal)) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        rdata      <= '0;
                    end else if (accept) begin
                        bus_we    <= mem_write_en;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_be    <= fmt_be;
                        bus_wdata <= fmt_wdata;
                        mode_q    <= l_s_mode;
                        off_q     <= addr[1:0];
                        cnt       <= '0;
                    end
                end
                ST_BUS: begin
                    // An ack in the final counted cycle still completes normally.
                    if (bus_ack) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        rdata      <= bus_we ? '0 : fmt_rdata;
                    end else if (timed_out) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        rdata      <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level model plus per-cycle monitor.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int unsigned TO = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  req_valid = 1'b0;
    logic                  req_ready;
    logic                  mem_read_en = 1'b0;
    logic                  mem_write_en = 1'b0;
    logic [L_S_MODE_W-1:0] l_s_mode = '0;
    logic [31:0]           addr = '0;
    logic [31:0]           wdata = '0;
    logic                  resp_valid;
    logic [31:0]           rdata;
    logic                  resp_err;
    logic                  bus_req;
    logic                  bus_we;
    logic [31:0]           bus_addr;
    logic [3:0]            bus_be;
    logic [31:0]           bus_wdata;
    logic                  bus_ack = 1'b0;
    logic [31:0]           bus_rdata = '0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .l_s_mode     (l_s_mode),
        .addr         (addr),
        .wdata        (wdata),
        .resp_valid   (resp_valid),
        .rdata        (rdata),
        .resp_err     (resp_err),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic m_misal(input logic [2:0] mode, input logic [31:0] a);
        case (mode)
            L_S_BYTE, L_S_BYTE_U: return 1'b0;
            L_S_HALF, L_S_HALF_U: return (a % 2) != 0;
            default:              return (a % 4) != 0;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] mode, input logic [31:0] a);
        int o;
        o = int'(a % 4);
        case (mode)
            L_S_BYTE, L_S_BYTE_U: return 4'(1 << o);
            L_S_HALF, L_S_HALF_U: return (o >= 2) ? 4'hC : 4'h3;
            default:              return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] m_wrep(input logic [2:0] mode, input logic [31:0] wd);
        case (mode)
            L_S_BYTE, L_S_BYTE_U: return (wd & 32'hFF) * 32'h0101_0101;
            L_S_HALF, L_S_HALF_U: return (wd & 32'hFFFF) * 32'h0001_0001;
            default:              return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] mode, input logic [31:0] a,
                                           input logic [31:0] w);
        int o;
        int v;
        o = int'(a % 4);
        case (mode)
            L_S_BYTE, L_S_BYTE_U: begin
                v = int'((w >> (8 * o)) & 32'hFF);
                if (mode == L_S_BYTE && v > 127) v = v - 256;
                return 32'(v);
            end
            L_S_HALF, L_S_HALF_U: begin
                v = int'(((o >= 2) ? (w >> 16) : w) & 32'hFFFF);
                if (mode == L_S_HALF && v > 32767) v = v - 65536;
                return 32'(v);
            end
            default: return w;
        endcase
    endfunction

    // Model state for the transaction in flight.
    bit          pending = 0;
    bit          exp_bus_on = 0;
    int          exp_lat = 0;
    int          exp_bus_n = 0;
    logic [31:0] exp_rdata = '0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_baddr = '0;
    logic [31:0] exp_bwdata = '0;
    logic [3:0]  exp_be = '0;
    logic        exp_we = 1'b0;
    int          ack_after = 0;
    logic [31:0] rword = '0;
    bit          force_ack = 0;
    bit          hold_on = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    int          cyc = 0;
    int          acc_cyc = 0;
    int          bus_n = 0;
    logic [31:0] got_rdata = '0;
    logic        got_err = 1'b0;
    int          got_lat = 0;
    logic [31:0] cap_addr = '0;
    logic [31:0] cap_wdata = '0;
    logic [3:0]  cap_be = '0;
    logic        cap_we = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle compare process; also acts as the memory-side responder.
    always @(negedge clk) begin
        if (bus_req) begin
            bus_n++;
            if (bus_n == 1) begin
                cap_addr = bus_addr; cap_wdata = bus_wdata; cap_be = bus_be; cap_we = bus_we;
            end
            chk("bus_req_expected", 32'(bus_req), 32'(exp_bus_on));
            chk("bus_addr", bus_addr, exp_baddr);
            chk("bus_we", 32'(bus_we), 32'(exp_we));
            chk("bus_be", 32'(bus_be), 32'(exp_be));
            if (exp_we) chk("bus_wdata", bus_wdata, exp_bwdata);
            bus_ack   = (ack_after != 0) && (bus_n == ack_after);
            bus_rdata = rword;
        end else begin
            bus_ack = force_ack;
        end
        if (resp_valid) begin
            chk("resp_expected", 32'(resp_valid), 32'(pending));
            got_rdata = rdata; got_err = resp_err; got_lat = cyc - acc_cyc + 1;
            if (pending) begin
                chk("resp_rdata", rdata, exp_rdata);
                chk("resp_err", 32'(resp_err), 32'(exp_err));
                chk("resp_latency", 32'(got_lat), 32'(exp_lat));
                chk("bus_cycles", 32'(bus_n), 32'(exp_bus_n));
                last_rdata = exp_rdata;
                last_err   = exp_err;
                hold_on    = 1;
            end
            pending    = 0;
            exp_bus_on = 0;
        end else begin
            if (pending && (cyc - acc_cyc + 1) > exp_lat) begin
                chk("resp_missing", 32'(resp_valid), 32'd1);
                pending    = 0;
                exp_bus_on = 0;
            end
            if (hold_on) begin
                chk("rdata_hold", rdata, last_rdata);
                chk("err_hold", 32'(resp_err), 32'(last_err));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic txn(input logic rd, input logic wr, input logic [2:0] mode,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rw, input int ack_n);
        logic err;
        int   n;
        err = (rd && wr) || m_misal(mode, a);
        if (err) begin
            exp_err = 1'b1; exp_rdata = '0; exp_lat = 1; exp_bus_n = 0; ack_after = 0;
        end else if (ack_n == 0) begin
            exp_err = 1'b1; exp_rdata = '0; exp_lat = TO + 1; exp_bus_n = TO; ack_after = 0;
        end else begin
            exp_err = 1'b0; exp_rdata = wr ? 32'd0 : m_load(mode, a, rw);
            exp_lat = ack_n + 1; exp_bus_n = ack_n; ack_after = ack_n;
        end
        exp_baddr  = a & 32'hFFFF_FFFC;
        exp_we     = wr;
        exp_be     = m_be(mode, a);
        exp_bwdata = m_wrep(mode, wd);
        rword      = rw;
        @(posedge clk); #1;
        bus_n = 0;
        req_valid = 1'b1; mem_read_en = rd; mem_write_en = wr;
        l_s_mode = mode; addr = a; wdata = wd;
        chk("req_ready_at_accept", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        req_valid = 1'b0; mem_read_en = 1'b0; mem_write_en = 1'b0;
        pending = 1; exp_bus_on = !err;
        n = 0;
        while (pending && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (pending) begin
            chk("txn_bound", 32'(pending), 32'd0);
            pending = 0; exp_bus_on = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_bus_be", 32'(bus_be), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; last_rdata = '0; last_err = 1'b0; hold_on = 1;

        // LB sign-extended, ack in first BUS cycle
        txn(1, 0, L_S_BYTE, 32'h1003, 32'h0, 32'h8011_2233, 1);
        chk("lb_rdata_lit", got_rdata, 32'hFFFF_FF80);
        chk("lb_err_lit", 32'(got_err), 32'd0);
        chk("lb_latency_lit", 32'(got_lat), 32'd2);

        // SH upper half
        txn(0, 1, L_S_HALF, 32'h2002, 32'hDEAD_BEEF, 32'h0, 1);
        chk("sh_be_lit", 32'(cap_be), 32'hC);
        chk("sh_wdata_lit", cap_wdata, 32'hBEEF_BEEF);
        chk("sh_addr_lit", cap_addr, 32'h2000);
        chk("sh_we_lit", 32'(cap_we), 32'd1);
        chk("sh_rdata_lit", got_rdata, 32'd0);

        // LW misaligned
        txn(1, 0, L_S_WORD, 32'h3001, 32'h0, 32'h0, 1);
        chk("lw_mis_err_lit", 32'(got_err), 32'd1);
        chk("lw_mis_latency_lit", 32'(got_lat), 32'd1);
        chk("lw_mis_bus_lit", 32'(bus_n), 32'd0);

        // LHU timeout
        txn(1, 0, L_S_HALF_U, 32'h10, 32'h0, 32'h0, 0);
        chk("lhu_to_bus_cycles_lit", 32'(bus_n), 32'd4);
        chk("lhu_to_err_lit", 32'(got_err), 32'd1);
        chk("lhu_to_rdata_lit", got_rdata, 32'd0);

        // Further load/store patterns
        txn(1, 0, L_S_BYTE_U, 32'h1001, 32'h0, 32'h8011_2233, 1);
        chk("lbu_rdata_lit", got_rdata, 32'h22);
        txn(1, 0, L_S_HALF, 32'h0002, 32'h0, 32'h8001_0000, 3);
        chk("lh_rdata_lit", got_rdata, 32'hFFFF_8001);
        txn(1, 0, L_S_HALF_U, 32'h0002, 32'h0, 32'h8001_0000, 2);
        txn(1, 0, L_S_WORD, 32'h0004, 32'h0, 32'h1234_5678, 2);
        txn(0, 1, L_S_BYTE, 32'h0005, 32'h1122_33A5, 32'h0, 1);
        chk("sb_wdata_lit", cap_wdata, 32'hA5A5_A5A5);
        chk("sb_be_lit", 32'(cap_be), 32'h2);
        txn(0, 1, L_S_WORD, 32'h0008, 32'hCAFE_0001, 32'h0, TO);
        chk("sw_last_cycle_ack_err_lit", 32'(got_err), 32'd0);
        txn(1, 1, L_S_WORD, 32'h0010, 32'h0, 32'h0, 1);
        txn(0, 1, L_S_HALF, 32'h2001, 32'h1234, 32'h0, 1);
        txn(1, 0, 3'd7, 32'h0002, 32'h0, 32'h0, 1);
        txn(1, 0, 3'd7, 32'h000C, 32'h0, 32'hCAFE_F00D, 1);
        chk("unk_mode_rdata_lit", got_rdata, 32'hCAFE_F00D);

        // Ignored request: both enables low
        @(posedge clk); #1;
        req_valid = 1'b1; mem_read_en = 1'b0; mem_write_en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("ignored_req_ready", 32'(req_ready), 32'd1);
            chk("ignored_bus_req", 32'(bus_req), 32'd0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;

        // Reset in second BUS cycle of an LW
        exp_baddr = 32'h40; exp_we = 1'b0; exp_be = 4'hF; ack_after = 0; rword = '0;
        @(posedge clk); #1;
        bus_n = 0;
        req_valid = 1'b1; mem_read_en = 1'b1; l_s_mode = L_S_WORD; addr = 32'h40;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_read_en = 1'b0; exp_bus_on = 1;
        @(posedge clk); #1;
        rst_n = 1'b0; hold_on = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_bus_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_bus_cycles_seen", 32'(bus_n), 32'd2);
        exp_bus_on = 0; last_rdata = '0; last_err = 1'b0; hold_on = 1;
        @(posedge clk); #1;
        rst_n = 1'b1; force_ack = 1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_req_ready", 32'(req_ready), 32'd1);
            chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
        end
        force_ack = 0;

        // Unit still works after abandoned transfer
        txn(1, 0, L_S_WORD, 32'h0044, 32'h0, 32'h0BAD_F00D, 1);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
